// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared register map, FSM encoding and reset values for spi_reg_ctrl
package spi_reg_pkg;

  localparam logic [6:0] REG_VERSION   = 7'h00;
  localparam logic [6:0] REG_FORCE_BT  = 7'h01;
  localparam logic [6:0] REG_UART_INV  = 7'h02;
  localparam logic [6:0] REG_TELEM_SEL = 7'h03;
  localparam logic [6:0] REG_SCRATCH   = 7'h04;
  localparam logic [6:0] REG_STATUS    = 7'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] RST_BYTE  = 8'h00;
  localparam logic [6:0] RST_ADDR  = 7'h00;
  localparam logic       RST_FORCE = 1'b0;

endpackage

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - FC configuration register storage, read mux, write decode and error counter
module spi_regfile
  import spi_reg_pkg::*;
#(
  parameter logic [7:0] FPGA_VER = 8'hC3
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       err_pulse,
  output logic       bootloader_force,
  output logic [7:0] uart_inverted,
  output logic [7:0] telemetry_con_sel,
  output logic [7:0] err_count
);

  logic [7:0] scratch;
  logic       wr_ok;
  logic       err_any;

  always_comb begin
    rd_data = RST_BYTE;
    case (rd_addr)
      REG_VERSION:   rd_data = FPGA_VER;
      REG_FORCE_BT:  rd_data = {7'b0, bootloader_force};
      REG_UART_INV:  rd_data = uart_inverted;
      REG_TELEM_SEL: rd_data = telemetry_con_sel;
      REG_SCRATCH:   rd_data = scratch;
      REG_STATUS:    rd_data = err_count;
      default:       rd_data = RST_BYTE;
    endcase
  end

  // Only 0x01..0x04 accept writes; RO and unmapped writes are counted as errors.
  assign wr_ok   = (wr_addr == REG_FORCE_BT) || (wr_addr == REG_UART_INV) ||
                   (wr_addr == REG_TELEM_SEL) || (wr_addr == REG_SCRATCH);
  assign err_any = err_pulse || (wr_en && !wr_ok);

  always_ff @(posedge clk_core) begin
    if (reset) begin
      bootloader_force  <= RST_FORCE;
      uart_inverted     <= RST_BYTE;
      telemetry_con_sel <= RST_BYTE;
      scratch           <= RST_BYTE;
      err_count         <= RST_BYTE;
    end else begin
      if (wr_en && wr_ok) begin
        case (wr_addr)
          REG_FORCE_BT:  bootloader_force  <= wr_data[0];
          REG_UART_INV:  uart_inverted     <= wr_data;
          REG_TELEM_SEL: telemetry_con_sel <= wr_data;
          REG_SCRATCH:   scratch           <= wr_data;
          default:       ;
        endcase
      end
      if (err_any && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI byte-stream command sequencer with auto-incrementing register access
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [7:0] FPGA_VER = 8'hC3,
  parameter int         NUM_REGS = 6
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       transaction_begin,
  input  logic       rx_byte_available,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       bootloader_force,
  output logic [7:0] uart_inverted,
  output logic [7:0] telemetry_con_sel,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  state_t     state, state_nxt;
  logic [1:0] rx_hist;
  logic       rx_evt, evt;
  logic [6:0] addr, rd_addr;
  logic       dir_wr;
  logic [7:0] rd_data;
  logic       rd_en, wr_en, rd_unmapped;

  always_ff @(posedge clk_core) begin
    if (reset) rx_hist <= 2'b00;
    else       rx_hist <= {rx_hist[0], rx_byte_available};
  end

  assign rx_evt = (rx_hist == 2'b01);
  // A new transaction always wins over a byte arriving in the same cycle.
  assign evt    = rx_evt && !transaction_begin;

  always_ff @(posedge clk_core) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (transaction_begin)              state_nxt = CMD;
    else if (state == CMD && rx_evt)    state_nxt = DATA;
  end

  always_comb begin
    busy    = (state != IDLE);
    rd_en   = evt && (((state == CMD) && !rx_byte[7]) || ((state == DATA) && !dir_wr));
    wr_en   = evt && (state == DATA) && dir_wr;
    rd_addr = (state == CMD) ? rx_byte[6:0] : addr;
  end

  assign rd_unmapped = rd_en && ({1'b0, rd_addr} >= NUM_REGS_B);

  always_ff @(posedge clk_core) begin
    if (reset) begin
      addr    <= RST_ADDR;
      tx_byte <= RST_BYTE;
      dir_wr  <= 1'b0;
    end else if (transaction_begin) begin
      addr    <= RST_ADDR;
      tx_byte <= RST_BYTE;
    end else if (evt && state == CMD) begin
      dir_wr <= rx_byte[7];
      if (rx_byte[7]) begin
        addr <= rx_byte[6:0];
      end else begin
        addr    <= rx_byte[6:0] + 7'd1;
        tx_byte <= rd_data;
      end
    end else if (evt && state == DATA) begin
      addr <= addr + 7'd1;
      if (!dir_wr) tx_byte <= rd_data;
    end
  end

  spi_regfile #(
    .FPGA_VER(FPGA_VER)
  ) u_regfile (
    .clk_core          (clk_core),
    .reset             (reset),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .wr_en             (wr_en),
    .wr_addr           (addr),
    .wr_data           (rx_byte),
    .err_pulse         (rd_unmapped),
    .bootloader_force  (bootloader_force),
    .uart_inverted     (uart_inverted),
    .telemetry_con_sel (telemetry_con_sel),
    .err_count         (err_count)
  );

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard testbench for spi_reg_ctrl
module tb_spi_reg_ctrl;

  localparam int S_TX = 0, S_BOOT = 1, S_UART = 2, S_TELEM = 3, S_ERR = 4, S_BUSY = 5;

  logic       clk_core = 1'b0;
  logic       reset = 1'b1;
  logic       transaction_begin = 1'b0;
  logic       rx_byte_available = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       bootloader_force;
  logic [7:0] uart_inverted;
  logic [7:0] telemetry_con_sel;
  logic       busy;
  logic [7:0] err_count;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e;
  logic [7:0] act;
  logic       chk_req = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #10 clk_core = ~clk_core;

  spi_reg_ctrl #(.FPGA_VER(8'hC3), .NUM_REGS(6)) dut (
    .clk_core          (clk_core),
    .reset             (reset),
    .transaction_begin (transaction_begin),
    .rx_byte_available (rx_byte_available),
    .rx_byte           (rx_byte),
    .tx_byte           (tx_byte),
    .bootloader_force  (bootloader_force),
    .uart_inverted     (uart_inverted),
    .telemetry_con_sel (telemetry_con_sel),
    .busy              (busy),
    .err_count         (err_count)
  );

  function automatic logic [7:0] pick(int sel);
    case (sel)
      S_TX:    return tx_byte;
      S_BOOT:  return {7'b0, bootloader_force};
      S_UART:  return uart_inverted;
      S_TELEM: return telemetry_con_sel;
      S_ERR:   return err_count;
      default: return {7'b0, busy};
    endcase
  endfunction

  always @(negedge clk_core) begin
    if (chk_req) begin
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = pick(e.sel);
        n_cmp++;
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %02h required %02h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [7:0] val);
    exp_t x;
    x.name = name; x.sel = sel; x.val = val;
    sbq.push_back(x);
  endtask

  task automatic chk();
    @(posedge clk_core); #1 chk_req = 1'b1;
    @(posedge clk_core); #1 chk_req = 1'b0;
  endtask

  task automatic begin_txn();
    @(posedge clk_core); #1 transaction_begin = 1'b1;
    @(posedge clk_core); #1 transaction_begin = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_core); #1 rx_byte = b; rx_byte_available = 1'b1;
    repeat (4) @(posedge clk_core);
    #1 rx_byte_available = 1'b0;
    repeat (2) @(posedge clk_core);
  endtask

  task automatic expect_all_reset(input string tag);
    expect_val({tag, "_tx"}, S_TX, 8'h00);
    expect_val({tag, "_boot"}, S_BOOT, 8'h00);
    expect_val({tag, "_uart"}, S_UART, 8'h00);
    expect_val({tag, "_telem"}, S_TELEM, 8'h00);
    expect_val({tag, "_err"}, S_ERR, 8'h00);
    expect_val({tag, "_busy"}, S_BUSY, 8'h00);
  endtask

  initial begin
    repeat (100000) @(posedge clk_core);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_core);
    #1 reset = 1'b0;
    expect_all_reset("rst");
    chk();

    // Read STATUS right after reset
    begin_txn();
    expect_val("begin_busy", S_BUSY, 8'h01);
    expect_val("begin_tx", S_TX, 8'h00);
    chk();
    send_byte(8'h05);
    expect_val("rd_status0", S_TX, 8'h00);
    chk();

    // VERSION then FORCE_BT via auto-increment
    begin_txn();
    send_byte(8'h00);
    expect_val("rd_version", S_TX, 8'hC3);
    chk();
    send_byte(8'hEE);
    expect_val("rd_force0", S_TX, 8'h00);
    expect_val("rd_ver_err", S_ERR, 8'h00);
    chk();

    // Write burst 0x01..0x04
    begin_txn();
    send_byte(8'h81);
    send_byte(8'h01);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h5A);
    expect_val("wr_boot", S_BOOT, 8'h01);
    expect_val("wr_uart", S_UART, 8'hA5);
    expect_val("wr_telem", S_TELEM, 8'h03);
    expect_val("wr_err", S_ERR, 8'h00);
    chk();

    // Read burst running into unmapped 0x06
    begin_txn();
    send_byte(8'h03);
    expect_val("rd_telem", S_TX, 8'h03); chk();
    send_byte(8'h00);
    expect_val("rd_scratch", S_TX, 8'h5A); chk();
    send_byte(8'h00);
    expect_val("rd_status", S_TX, 8'h00); chk();
    send_byte(8'h00);
    expect_val("rd_unmapped", S_TX, 8'h00);
    expect_val("rd_unmapped_err", S_ERR, 8'h01);
    chk();

    // RO write, then address wrap 0x7F -> 0x00
    begin_txn();
    send_byte(8'h80);
    send_byte(8'h77);
    expect_val("wr_ro_err", S_ERR, 8'h02); chk();
    begin_txn();
    send_byte(8'hFF);
    send_byte(8'h11);
    send_byte(8'h22);
    expect_val("wrap_err", S_ERR, 8'h04);
    expect_val("wrap_uart", S_UART, 8'hA5);
    expect_val("wrap_boot", S_BOOT, 8'h01);
    chk();

    // transaction_begin colliding with rx_evt drops the byte
    begin_txn();
    send_byte(8'h82);
    send_byte(8'h3C);
    expect_val("pre_coll_uart", S_UART, 8'h3C); chk();
    @(posedge clk_core); #1 rx_byte = 8'h99; rx_byte_available = 1'b1;
    @(posedge clk_core); #1 transaction_begin = 1'b1;
    @(posedge clk_core); #1 transaction_begin = 1'b0;
    repeat (2) @(posedge clk_core);
    #1 rx_byte_available = 1'b0;
    repeat (2) @(posedge clk_core);
    expect_val("coll_tx", S_TX, 8'h00);
    expect_val("coll_busy", S_BUSY, 8'h01);
    expect_val("coll_telem", S_TELEM, 8'h03);
    expect_val("coll_uart", S_UART, 8'h3C);
    expect_val("coll_err", S_ERR, 8'h04);
    chk();
    send_byte(8'h02);
    expect_val("coll_cmd_rd", S_TX, 8'h3C); chk();

    // err_count saturation
    for (int i = 0; i < 260; i++) begin
      begin_txn();
      send_byte(8'h7F);
    end
    expect_val("sat_err", S_ERR, 8'hFF); chk();
    begin_txn();
    send_byte(8'h05);
    expect_val("sat_status", S_TX, 8'hFF);
    expect_val("sat_err_hold", S_ERR, 8'hFF);
    chk();

    // Reset mid-burst
    begin_txn();
    send_byte(8'h82);
    @(posedge clk_core); #1 reset = 1'b1;
    repeat (2) @(posedge clk_core);
    expect_all_reset("midrst");
    chk();
    #1 reset = 1'b0;
    begin_txn();
    send_byte(8'h04);
    expect_val("post_rst_scratch", S_TX, 8'h00); chk();
    send_byte(8'h00);
    expect_val("post_rst_status", S_TX, 8'h00);
    expect_val("post_rst_err", S_ERR, 8'h00);
    chk();

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk_core);
    if (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Sequences the byte stream from spi_slave into a command/register-access protocol: one command byte, then a burst of data bytes with address auto-increment.
- Owns the FC-side configuration register file: bootloader force pin, UART inversion mask, telemetry connector select, scratch and status.
- Sits between spi_slave and the top-level pin muxing, replacing ad-hoc single-register SPI decode in top.

Parameters:
- FPGA_VER, 8'hC3, value returned by register 0x00.
- NUM_REGS, 6, number of mapped registers (addresses 0..NUM_REGS-1).

Ports:
- clk_core  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- transaction_begin  in  1  one-cycle pulse from spi_slave at SS assertion.
- rx_byte_available  in  1  level from spi_slave; its rising edge marks a new rx_byte.
- rx_byte  in  8  received MOSI byte, valid at the rx_byte_available rising edge.
- tx_byte  out  8  byte spi_slave shifts out on the next byte slot.
- bootloader_force  out  1  drives BOOTLOADER_FORCE_PIN.
- uart_inverted  out  8  per-UART inversion mask.
- telemetry_con_sel  out  8  bit0: 1 = telemetry port used as I2C, 0 = UART.
- busy  out  1  high in CMD or DATA state.
- err_count  out  8  saturating count of accesses to unmapped or read-only addresses.

Behaviour:
- Clock is clk_core only; reset is synchronous, active-high. On reset: state IDLE, tx_byte=0, bootloader_force=0, uart_inverted=0, telemetry_con_sel=0, scratch=0, err_count=0, busy=0, addr=0.
- Edge detect: 2-flop history of rx_byte_available; rx_evt = (hist==2'b01). rx_evt fires 2 cycles after the input rises.
- Register map (7-bit address):
  - 0x00 VERSION, RO, returns FPGA_VER.
  - 0x01 FORCE_BT, RW, bit0 only; other bits read 0.
  - 0x02 UART_INV, RW.
  - 0x03 TELEM_SEL, RW.
  - 0x04 SCRATCH, RW.
  - 0x05 STATUS, RO, returns err_count.
- Command byte: bit7=1 is a write, bit7=0 is a read; bits[6:0] are the start address.
- FSM states:
  - IDLE: waits for transaction_begin.
  - CMD: on transaction_begin, tx_byte<=0 and go to CMD. On rx_evt, latch dir and addr=rx_byte[6:0]. If read: tx_byte<=rd(addr), addr<=addr+1. Then go to DATA.
  - DATA, write: on rx_evt, wr(addr, rx_byte), addr<=addr+1.
  - DATA, read: on rx_evt, tx_byte<=rd(addr), addr<=addr+1; rx_byte is ignored.
- No end-of-transaction signal: DATA persists until the next transaction_begin or reset.
- Address is 7 bits and wraps 0x7F to 0x00.
- Unmapped read (addr>=NUM_REGS) returns 0x00 and increments err_count.
- Unmapped write, or a write to an RO register (0x00, 0x05), is ignored and increments err_count.
- err_count saturates at 0xFF.
- Register writes take effect on the cycle after rx_evt (registered outputs).
- transaction_begin in any state aborts the current burst and restarts at CMD with tx_byte=0.
- transaction_begin and rx_evt in the same cycle: transaction_begin wins and the rx_evt is dropped.
- reset together with any event: reset wins.
- Reset mid-burst: all registers return to reset values and state is IDLE.
- rx_evt in IDLE is ignored; no error is counted.

Decomposition:
- Shared package spi_reg_pkg holds:
  - address constants REG_VERSION..REG_STATUS;
  - state encoding IDLE/CMD/DATA;
  - reset values.
- One sub-module, spi_regfile: register storage, read mux, write decode and err_count, with ports rd_addr/rd_data/wr_en/wr_addr/wr_data/err_pulse.
- spi_reg_ctrl keeps the edge detector, FSM and address counter.

Test Plan:
- Reset, then read 0x05 and all outputs → all outputs 0, busy=0; read returns 0x00.
- Begin, cmd 0x00, one dummy byte → tx_byte=0xC3 after the cmd rx_evt; then tx_byte=0x00 (reg 0x01); err_count stays 0.
- Begin, cmd 0x81, data 0x01,0xA5,0x03,0x5A → bootloader_force=1, uart_inverted=0xA5, telemetry_con_sel=0x03, scratch=0x5A.
- Begin, cmd 0x03, then 3 dummy bytes → tx_byte sequence 0x03, 0x5A, err_count value, then 0x00 (addr 0x06 unmapped); err_count increments once.
- Begin, cmd 0x80, data 0x77 → write to VERSION ignored, err_count+1. Then cmd 0xFF, data 0x11,0x22 → addr wraps 0x7F→0x00, both writes rejected, err_count+2.
- Mid-burst transaction_begin asserted in the same cycle as rx_evt → byte dropped, no register change, state=CMD, tx_byte=0. Mid-burst reset → all outputs return to reset values.
